// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging three register-file write requesters onto one registered write port.
// One-cycle accept-to-write latency; stall (or clr) withholds all grants and ptr holds.
module regfile_write_arbiter (
   input  logic        clock,
   input  logic        clr,
   input  logic [2:0]  req_valid,
   input  logic [14:0] req_addr,
   input  logic [95:0] req_data,
   input  logic        stall,
   output logic [2:0]  req_ready,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] ctrl_writeData,
   output logic [1:0]  grant_id,
   output logic [31:0] pending_mask,
   output logic [15:0] wr_count
);

   logic [1:0]  ptr;
   logic [1:0]  win;
   logic        win_vld;
   logic        xfer;
   logic [1:0]  c0, c1, c2;
   logic [4:0]  addr_a [3];
   logic [31:0] data_a [3];

   function automatic logic [1:0] rr_next(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_unpack
      assign addr_a[g] = req_addr[5*g +: 5];
      assign data_a[g] = req_data[32*g +: 32];
   end

   // Search order starts at ptr and wraps mod 3.
   always_comb begin
      c0      = ptr;
      c1      = rr_next(c0);
      c2      = rr_next(c1);
      win     = c0;
      win_vld = 1'b1;
      if (req_valid[c0])      win = c0;
      else if (req_valid[c1]) win = c1;
      else if (req_valid[c2]) win = c2;
      else                    win_vld = 1'b0;
   end

   always_comb begin
      req_ready = 3'b000;
      if (win_vld && !stall && !clr) req_ready[win] = 1'b1;
   end

   assign xfer = |req_ready;

   always_ff @(posedge clock or posedge clr) begin
      if (clr) begin
         ptr              <= 2'd0;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= 5'd0;
         ctrl_writeData   <= 32'd0;
         grant_id         <= 2'd0;
      end else if (xfer) begin
         ptr              <= rr_next(win);
         ctrl_writeEnable <= (addr_a[win] != 5'd0);
         ctrl_writeReg    <= addr_a[win];
         ctrl_writeData   <= data_a[win];
         grant_id         <= win;
      end else begin
         ctrl_writeEnable <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge clr) begin
      if (clr)
         wr_count <= 16'd0;
      else if (ctrl_writeEnable && wr_count != 16'hFFFF)
         wr_count <= wr_count + 16'd1;
   end

   // Register 0 is hardwired, so it never reads as pending.
   always_comb begin
      pending_mask = 32'd0;
      for (int i = 0; i < 3; i++)
         if (req_valid[i]) pending_mask[addr_a[i]] = 1'b1;
      if (ctrl_writeEnable) pending_mask[ctrl_writeReg] = 1'b1;
      pending_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench: driver pushes expected writes on accept, monitor pops on each write.
module tb_regfile_write_arbiter;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
      logic [1:0]  g;
   } wr_t;

   logic        clock = 1'b0;
   logic        clr;
   logic [2:0]  req_valid;
   logic        stall;
   logic [4:0]  a [3];
   logic [31:0] d [3];
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] ctrl_writeData;
   logic [1:0]  grant_id;
   logic [31:0] pending_mask;
   logic [15:0] wr_count;

   int   total = 0;
   int   bad = 0;
   wr_t  exp_q [$];
   logic        we_s;
   logic [31:0] pm_s;
   logic [15:0] cnt_s;

   assign req_addr = {a[2], a[1], a[0]};
   assign req_data = {d[2], d[1], d[0]};

   always #5 clock = ~clock;

   regfile_write_arbiter dut (
      .clock(clock), .clr(clr), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .stall(stall), .req_ready(req_ready),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .ctrl_writeData(ctrl_writeData), .grant_id(grant_id),
      .pending_mask(pending_mask), .wr_count(wr_count)
   );

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // One bus cycle: drive, check ready mid-cycle, predict the write, snapshot outputs.
   task automatic cyc(input logic [2:0] v, input logic s, input logic [2:0] er, input logic push);
      logic [1:0] w;
      req_valid = v;
      stall     = s;
      @(negedge clock);
      chk("ready", 64'(req_ready), 64'(er));
      we_s  = ctrl_writeEnable;
      pm_s  = pending_mask;
      cnt_s = wr_count;
      if (push && er != 3'b000) begin
         w = er[0] ? 2'd0 : (er[1] ? 2'd1 : 2'd2);
         if (a[w] != 5'd0) exp_q.push_back('{r: a[w], d: d[w], g: w});
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req_valid = 3'b000;
      clr = 1'b1;
      #1;
      chk("rst_we", 64'(ctrl_writeEnable), 64'd0);
      chk("rst_cnt", 64'(wr_count), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      #1;
      clr = 1'b0;
   endtask

   // Monitor: every asserted write must match the oldest predicted write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clock);
         if (ctrl_writeEnable) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got reg %0d data %0h, required none", ctrl_writeReg, ctrl_writeData);
            end else begin
               e = exp_q.pop_front();
               chk("wr_reg", 64'(ctrl_writeReg), 64'(e.r));
               chk("wr_data", 64'(ctrl_writeData), 64'(e.d));
               chk("grant_id", 64'(grant_id), 64'(e.g));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] e;
      clr = 1'b1;
      stall = 1'b0;
      req_valid = 3'b111;
      a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
      d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
      #2;
      chk("reset_ready", 64'(req_ready), 64'd0);
      chk("reset_we", 64'(ctrl_writeEnable), 64'd0);
      chk("reset_reg", 64'(ctrl_writeReg), 64'd0);
      chk("reset_data", 64'(ctrl_writeData), 64'd0);
      chk("reset_gid", 64'(grant_id), 64'd0);
      chk("reset_cnt", 64'(wr_count), 64'd0);
      req_valid = 3'b000;
      @(negedge clock);
      clr = 1'b0;
      @(posedge clock);
      #1;

      // Single request from requester 1.
      a[1] = 5'd7; d[1] = 32'hDEADBEEF;
      cyc(3'b010, 1'b0, 3'b010, 1'b1);
      chk("single_pend_req", 64'(pm_s), 64'h80);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("single_pend_out", 64'(pm_s), 64'h80);
      chk("single_we", 64'(we_s), 64'd1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("single_cnt", 64'(cnt_s), 64'd1);

      // Round robin with all three requesting.
      do_reset();
      a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
      d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
      for (int i = 0; i < 6; i++) begin
         e = 3'b001 << (i % 3);
         cyc(3'b111, 1'b0, e, 1'b1);
         if (i == 1) chk("rr_pend", 64'(pm_s), 64'hE);
         if (i > 0) chk("rr_we", 64'(we_s), 64'd1);
      end
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("rr_cnt", 64'(cnt_s), 64'd6);

      // Address-zero write is accepted but never enabled.
      a[0] = 5'd0; d[0] = 32'h5;
      cyc(3'b001, 1'b0, 3'b001, 1'b1);
      chk("a0_pend_req", 64'(pm_s), 64'd0);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("a0_we", 64'(we_s), 64'd0);
      chk("a0_pend_out", 64'(pm_s), 64'd0);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("a0_cnt", 64'(cnt_s), 64'd6);

      // Move ptr to 2, then stall with requesters 0 and 2 waiting.
      a[1] = 5'd9; d[1] = 32'h11;
      cyc(3'b010, 1'b0, 3'b010, 1'b1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      a[0] = 5'd4; d[0] = 32'h40; a[2] = 5'd6; d[2] = 32'h60;
      for (int i = 0; i < 3; i++) begin
         cyc(3'b101, 1'b1, 3'b000, 1'b1);
         chk("stall_we", 64'(we_s), 64'd0);
      end
      cyc(3'b101, 1'b0, 3'b100, 1'b1);
      cyc(3'b001, 1'b0, 3'b001, 1'b1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);

      // Reset between acceptance and output: write is dropped, ptr returns to 0.
      a[1] = 5'd12; d[1] = 32'h77;
      cyc(3'b010, 1'b0, 3'b010, 1'b0);
      do_reset();
      a[1] = 5'd13; d[1] = 32'h88; a[2] = 5'd14; d[2] = 32'h99;
      cyc(3'b110, 1'b0, 3'b010, 1'b1);
      chk("clr_drop_we", 64'(we_s), 64'd0);
      cyc(3'b100, 1'b0, 3'b100, 1'b1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("clr_cnt", 64'(cnt_s), 64'd2);

      // Saturation of the write counter.
      do_reset();
      a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
      d[0] = 32'hB0; d[1] = 32'hB1; d[2] = 32'hB2;
      for (int i = 0; i < 65535; i++) begin
         e = 3'b001 << (i % 3);
         cyc(3'b111, 1'b0, e, 1'b1);
      end
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("sat_pre", 64'(cnt_s), 64'hFFFE);
      cyc(3'b001, 1'b0, 3'b001, 1'b1);
      chk("sat_full", 64'(cnt_s), 64'hFFFF);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      cyc(3'b000, 1'b0, 3'b000, 1'b1);
      chk("sat_hold", 64'(cnt_s), 64'hFFFF);

      @(negedge clock);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters: none; widths fixed at 3 requesters, 5-bit register address, 32-bit data.
REQ-002 The block SHALL have exactly one clock; reset is asynchronous and active-high, with ports named clock and clr.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 clr  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  3  bit i = requester i has a write pending.
REQ-006 req_addr  input  15  requester i target register at [5i+4:5i].
REQ-007 req_data  input  96  requester i write data at [32i+31:32i].
REQ-008 stall  input  1  1 = grant nothing this cycle.
REQ-009 req_ready  output  3  one-hot or zero; bit i = requester i accepted this cycle.
REQ-010 ctrl_writeEnable  output  1  register-file write enable (registered).
REQ-011 ctrl_writeReg  output  5  register-file write address (registered).
REQ-012 ctrl_writeData  output  32  register-file write data (registered).
REQ-013 grant_id  output  2  index of requester that produced the current output write.
REQ-014 pending_mask  output  32  bit r = register r has an outstanding or in-flight write.
REQ-015 wr_count  output  16  count of cycles with ctrl_writeEnable=1, saturating.

Function
REQ-016 Transfer occurs on a rising edge where req_valid[i]=1 and req_ready[i]=1; requesters SHALL hold valid, addr and data stable until ready; the block SHALL NOT check this.
REQ-017 Round-robin pointer ptr in {0,1,2}; search order ptr, ptr+1, ptr+2 mod 3; the first valid requester wins.
REQ-018 req_ready SHALL be combinational from req_valid, ptr and stall; at most one bit set; all zero when stall=1 or clr=1.
REQ-019 On a transfer by winner w: ptr <= (w+1) mod 3; with no transfer, ptr holds.
REQ-020 Latency: one cycle; on the edge after acceptance, ctrl_writeReg/ctrl_writeData/grant_id take w's addr/data/index.
REQ-021 On that same edge, ctrl_writeEnable <= 1 unless the accepted addr is 0; an addr-0 write is accepted (ready=1) but writeEnable <= 0.
REQ-022 Cycle with no transfer: ctrl_writeEnable <= 0; ctrl_writeReg, ctrl_writeData and grant_id hold their previous values.
REQ-023 Same-address requests from different requesters are serialised in grant order; the later write wins in the register file.
REQ-024 pending_mask = OR over i of onehot(req_addr[i]) where req_valid[i]=1, ORed with onehot(ctrl_writeReg) when ctrl_writeEnable=1; bit 0 is always 0; purely combinational.
REQ-025 wr_count increments by 1 on each edge where ctrl_writeEnable=1; holds at 16'hFFFF.
REQ-026 stall deasserting SHALL resume arbitration from the held ptr with no lost or duplicated grant.

Reset
REQ-027 While clr=1: ptr=0, ctrl_writeEnable=0, ctrl_writeReg=0, ctrl_writeData=0, grant_id=0, wr_count=0, req_ready=0, asynchronously.
REQ-028 clr asserted mid-stream SHALL drop the in-flight output write (writeEnable forced to 0 immediately); after clr falls, requester 0 has first priority.

Verification
REQ-029 Single request: valid=3'b010, addr1=7, data1=32'hDEADBEEF -> ready=3'b010 same cycle; next cycle writeEnable=1, writeReg=7, writeData=32'hDEADBEEF, grant_id=1.
REQ-030 Round-robin: valid=3'b111 held for 6 cycles after reset -> grants in order 0,1,2,0,1,2; writeEnable=1 on 6 consecutive cycles; wr_count=6.
REQ-031 Addr zero: valid=3'b001, addr0=0 -> ready=3'b001; next cycle writeEnable=0; wr_count unchanged; pending_mask bit 0 = 0.
REQ-032 Stall: valid=3'b101, ptr=2, stall=1 for 3 cycles -> ready=0, writeEnable=0 throughout; on release, requester 2 granted first, then 0.
REQ-033 Reset mid-op: grant to requester 1 accepted, clr pulsed before the next edge -> writeEnable=0, wr_count=0; after release with valid=3'b110, requester 1 is granted first.
REQ-034 Saturation: preload via 65535 writes -> wr_count=16'hFFFF; a further write leaves it at 16'hFFFF.
